pipeline_stall_controller: RTL
==============================

// Module: pipeline_stall_controller
// PURPOSE
//  Central hazard/stall sequencer for the 5-stage RV32 pipeline.
//  - Generates per-register hold (BUSYWAIT), flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  - Inputs: cache busywaits, EX-stage branch resolution, ID-stage load-use detection.
//  - After reset, holds the PC for a fixed window while the pipeline drains to NOPs.
//  - Exposes its state and saturating stall/flush performance counters.
// PARAMETERS
//  CNT_W        16  width of STALL_CYCLES / FLUSH_COUNT counters
//  INIT_CYCLES  4   post-reset PC hold window in cycles; legal range 2..15
// PORTS
//  CLK            in   1      clock; all state changes on the rising edge
//  RESET          in   1      asynchronous reset, active-low
//  INST_BUSYWAIT  in   1      instruction cache not ready
//  DATA_BUSYWAIT  in   1      data cache not ready (MEM stage)
//  BRANCH_TAKEN   in   1      EX stage resolved a taken branch or jump
//  ID_EX_MEM_READ in   1      instruction in EX is a load
//  ID_EX_RD       in   5      destination register of the instruction in EX
//  IF_ID_RS1      in   5      rs1 of the instruction in ID
//  IF_ID_RS2      in   5      rs2 of the instruction in ID
//  RS1_USED       in   1      ID instruction reads rs1
//  RS2_USED       in   1      ID instruction reads rs2
//  PC_HOLD        out  1      PC keeps its value
//  IF_ID_HOLD     out  1      BUSYWAIT to IF/ID
//  IF_ID_FLUSH    out  1      IF/ID loads NOP at the next edge
//  ID_EX_HOLD     out  1      BUSYWAIT to ID/EX
//  ID_EX_BUBBLE   out  1      ID/EX loads zeroed controls at the next edge
//  EX_MEM_HOLD    out  1      BUSYWAIT to EX/MEM
//  MEM_WB_HOLD    out  1      BUSYWAIT to MEM/WB
//  STATE          out  2      INIT=0, RUN=1, MEM_WAIT=2, INST_WAIT=3
//  STALL_CYCLES   out  CNT_W  count of cycles with PC_HOLD=1, excluding INIT
//  FLUSH_COUNT    out  CNT_W  count of branch redirect flushes
// BEHAVIOUR
//  - Control outputs are combinational (Mealy) from STATE and the inputs. STATE, the init counter and the perf counters are registered.
//  - While RESET=0 (asynchronous):
//    - STATE=INIT, init counter = INIT_CYCLES-1, both perf counters = 0.
//    - Outputs: PC_HOLD=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1, all other holds 0.
//  - INIT:
//    - Outputs as in reset; all hazard inputs ignored.
//    - Init counter decrements each edge; on the edge where it is 0, STATE becomes RUN.
//    - Result: exactly INIT_CYCLES edges in INIT after reset release.
//  - Load-use hazard:
//    - LU = ID_EX_MEM_READ & (ID_EX_RD!=0) & ((RS1_USED & IF_ID_RS1==ID_EX_RD) | (RS2_USED & IF_ID_RS2==ID_EX_RD)).
//  - RUN, MEM_WAIT and INST_WAIT use one priority chain, first match wins:
//    1. DATA_BUSYWAIT=1
//       - PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD all 1; no flush, no bubble.
//       - next STATE=MEM_WAIT.
//    2. BRANCH_TAKEN=1
//       - IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_HOLD=0 (target loads).
//       - Overrides LU and INST_BUSYWAIT.
//       - FLUSH_COUNT increments; next STATE=RUN.
//    3. LU=1
//       - PC_HOLD=1, IF_ID_HOLD=1, ID_EX_BUBBLE=1.
//       - next STATE=RUN; the hazard clears naturally after 1 cycle.
//    4. INST_BUSYWAIT=1
//       - PC_HOLD=1, IF_ID_FLUSH=1.
//       - next STATE=INST_WAIT.
//    5. Otherwise
//       - all outputs 0; next STATE=RUN.
//  - A branch arriving during a data stall: the pipeline is frozen, so BRANCH_TAKEN persists and is serviced on the first cycle after DATA_BUSYWAIT falls. No latching required.
//  - Hold has priority over flush/bubble; hold and flush/bubble are never asserted together on the same register.
//  - STALL_CYCLES increments on every edge where PC_HOLD=1 and STATE!=INIT; saturates at 2^CNT_W-1.
//  - FLUSH_COUNT saturates at 2^CNT_W-1.
//  - Reset mid-operation, in any state: immediate return to the INIT outputs and cleared counters, with no edge required.
// TESTING
//  T1 RESET=0 for 3 cycles, then release (INIT_CYCLES=4)
//     -> PC_HOLD=1 and STATE=0 for 4 edges; STATE=1 after the 4th edge; counters 0.
//  T2 ID_EX_MEM_READ=1, ID_EX_RD=5, IF_ID_RS1=5, RS1_USED=1 for one cycle
//     -> PC_HOLD=IF_ID_HOLD=ID_EX_BUBBLE=1; STALL_CYCLES=1.
//     Repeat with ID_EX_RD=0 -> all outputs 0.
//  T3 DATA_BUSYWAIT=1 for 3 cycles
//     -> all five holds=1, STATE=2, STALL_CYCLES+=3.
//     DATA_BUSYWAIT=0 -> holds 0, STATE=1.
//  T4 BRANCH_TAKEN=1 with LU=1 and INST_BUSYWAIT=1
//     -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_HOLD=0, FLUSH_COUNT=1.
//     Same with DATA_BUSYWAIT=1 -> holds only, FLUSH_COUNT unchanged.
//  T5 CNT_W=4, 20 consecutive INST_BUSYWAIT cycles
//     -> STATE=3 throughout, STALL_CYCLES=15 (saturated).
//  T6 RESET=0 mid-MEM_WAIT (between edges)
//     -> STATE=0, counters 0, PC_HOLD=1, EX_MEM_HOLD=0 before the next edge.

Source files
------------

// File: rtl/pipeline_stall_controller_if.sv
// Purpose: hazard inputs and stall/flush controls exchanged between the
//          pipeline datapath and the stall controller.
// Ports (signals):
//   pipeline -> controller : INST_BUSYWAIT, DATA_BUSYWAIT, BRANCH_TAKEN,
//                            ID_EX_MEM_READ, ID_EX_RD, IF_ID_RS1, IF_ID_RS2,
//                            RS1_USED, RS2_USED
//   controller -> pipeline : PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD,
//                            ID_EX_BUBBLE, EX_MEM_HOLD, MEM_WB_HOLD, STATE,
//                            STALL_CYCLES, FLUSH_COUNT
// master = pipeline side, slave = stall controller.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             INST_BUSYWAIT;
    logic             DATA_BUSYWAIT;
    logic             BRANCH_TAKEN;
    logic             ID_EX_MEM_READ;
    logic [4:0]       ID_EX_RD;
    logic [4:0]       IF_ID_RS1;
    logic [4:0]       IF_ID_RS2;
    logic             RS1_USED;
    logic             RS2_USED;

    logic             PC_HOLD;
    logic             IF_ID_HOLD;
    logic             IF_ID_FLUSH;
    logic             ID_EX_HOLD;
    logic             ID_EX_BUBBLE;
    logic             EX_MEM_HOLD;
    logic             MEM_WB_HOLD;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CYCLES;
    logic [CNT_W-1:0] FLUSH_COUNT;

    modport master (
        output INST_BUSYWAIT, DATA_BUSYWAIT, BRANCH_TAKEN, ID_EX_MEM_READ,
               ID_EX_RD, IF_ID_RS1, IF_ID_RS2, RS1_USED, RS2_USED,
        input  PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
               EX_MEM_HOLD, MEM_WB_HOLD, STATE, STALL_CYCLES, FLUSH_COUNT
    );

    modport slave (
        input  INST_BUSYWAIT, DATA_BUSYWAIT, BRANCH_TAKEN, ID_EX_MEM_READ,
               ID_EX_RD, IF_ID_RS1, IF_ID_RS2, RS1_USED, RS2_USED,
        output PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE,
               EX_MEM_HOLD, MEM_WB_HOLD, STATE, STALL_CYCLES, FLUSH_COUNT
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Purpose: central hazard/stall sequencer for the 5-stage RV32 pipeline.
//          Produces per-register hold, flush and bubble controls, holds the
//          PC for INIT_CYCLES edges after reset, and keeps saturating
//          stall/flush performance counters.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous reset, active-low
//   ctl   : slave side of pipeline_stall_controller_if (hazard inputs in,
//           Mealy control outputs + registered STATE/counters out)
module pipeline_stall_controller #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    pipeline_stall_controller_if.slave    ctl
);

    localparam int unsigned   INIT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_MEM_WAIT  = 2'd2,
        ST_INST_WAIT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0]    flush_q, flush_d;

    logic lu_c;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c;
    logic id_ex_bubble_c, ex_mem_hold_c, mem_wb_hold_c;

    // State, init window counter and perf counters
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_INIT;
            init_cnt_q <= INIT_W'(INIT_CYCLES - 1);
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    // Priority chain: data stall > branch redirect > load-use > fetch stall
    always_comb begin
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_mem_hold_c  = 1'b0;
        mem_wb_hold_c  = 1'b0;
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        stall_d        = stall_q;
        flush_d        = flush_q;

        lu_c = ctl.ID_EX_MEM_READ && (ctl.ID_EX_RD != 5'd0) &&
               ((ctl.RS1_USED && (ctl.IF_ID_RS1 == ctl.ID_EX_RD)) ||
                (ctl.RS2_USED && (ctl.IF_ID_RS2 == ctl.ID_EX_RD)));

        if (state_q == ST_INIT) begin
            // Drain the pipeline to NOPs; hazard inputs are meaningless here
            pc_hold_c      = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            if (init_cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                init_cnt_d = init_cnt_q - INIT_W'(1);
            end
        end else if (ctl.DATA_BUSYWAIT) begin
            // Whole pipeline frozen; a pending branch simply waits it out
            pc_hold_c     = 1'b1;
            if_id_hold_c  = 1'b1;
            id_ex_hold_c  = 1'b1;
            ex_mem_hold_c = 1'b1;
            mem_wb_hold_c = 1'b1;
            state_d       = ST_MEM_WAIT;
        end else if (ctl.BRANCH_TAKEN) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_d        = ST_RUN;
            if (flush_q != CNT_MAX) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end else if (lu_c) begin
            pc_hold_c      = 1'b1;
            if_id_hold_c   = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_d        = ST_RUN;
        end else if (ctl.INST_BUSYWAIT) begin
            pc_hold_c     = 1'b1;
            if_id_flush_c = 1'b1;
            state_d       = ST_INST_WAIT;
        end else begin
            state_d = ST_RUN;
        end

        if ((state_q != ST_INIT) && pc_hold_c && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    assign ctl.PC_HOLD      = pc_hold_c;
    assign ctl.IF_ID_HOLD   = if_id_hold_c;
    assign ctl.IF_ID_FLUSH  = if_id_flush_c;
    assign ctl.ID_EX_HOLD   = id_ex_hold_c;
    assign ctl.ID_EX_BUBBLE = id_ex_bubble_c;
    assign ctl.EX_MEM_HOLD  = ex_mem_hold_c;
    assign ctl.MEM_WB_HOLD  = mem_wb_hold_c;
    assign ctl.STATE        = state_q;
    assign ctl.STALL_CYCLES = stall_q;
    assign ctl.FLUSH_COUNT  = flush_q;

endmodule
